fp_normalize_pack: RTL and testbench
====================================

FP_NORMALIZE_PACK -- requirements
Module: fp_normalize_pack

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: raw sum present.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a raw sum.
REQ-005 SHALL have port in_sign, input, 1 bit: sign of the sum.
REQ-006 SHALL have port in_exp, input, 8 bits: biased exponent of the sum.
REQ-007 SHALL have port in_mantis, input, 28 bits: [27] carry, [26] hidden one, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-008 SHALL have port in_loss, input, 1 bit: bits lost during alignment, ORed into sticky.
REQ-009 SHALL have port out_valid, output, 1 bit: packed result present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port result, output, 32 bits: IEEE-754 single.
REQ-012 SHALL have port flags, output, 3 bits: {overflow, underflow, inexact}.

Function
REQ-013 SHALL implement the FSM IDLE -> NORM -> ROUND -> DONE -> IDLE; in_ready = (state==IDLE).
REQ-014 SHALL latch sign, exp and mantissa, with sticky |= in_loss, on in_valid&&in_ready, then go to NORM.
REQ-015 In NORM, if mant[27]=1, SHALL shift right one place (shifted-out bit ORed into sticky), exp+1, and go to ROUND.
REQ-016 In NORM, if mant[26]=1, or mant=0, or exp<=1, SHALL go to ROUND.
REQ-017 In NORM, otherwise SHALL shift left one place, exp-1, and stay in NORM, one bit per cycle.
REQ-018 SHALL round to nearest-even in ROUND: increment when G&&(R||S||frac[0]).
REQ-019 SHALL set inexact = G|R|S.
REQ-020 On rounding carry out of the hidden bit, SHALL set mantissa to 1.0 and exp+1.
REQ-021 With k left shifts, SHALL assert out_valid after rising edge 2+k counted from the accept edge; max k = 25.
REQ-022 SHALL pack result = {sign, exp[7:0], frac[22:0]}.
REQ-023 A zero mantissa SHALL give result 0x00000000 with flags 0.
REQ-024 Hidden bit still 0 at exp==1 SHALL pack an exp field of 0 (denormal); underflow=1 if inexact.
REQ-025 Final exp >=255 SHALL give {sign, 0xFF, 0}, overflow=1, inexact=1.
REQ-026 in_exp==255 SHALL pass through unrounded {sign, 0xFF, mant[25:3]} with flags 0.
REQ-027 In DONE, SHALL hold out_valid, result and flags stable until out_ready.
REQ-028 SHALL go DONE -> IDLE on out_valid&&out_ready.
REQ-029 SHALL ignore in_valid outside IDLE.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, out_valid=0, result=0, flags=0 and clear internal registers, including mid-NORM or in DONE.
REQ-031 SHALL have in_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Package fp_pkg SHALL hold the state enum, EXP_W=8, MANT_W=28, FRAC_W=23, EXP_MAX=255 and BIAS=127.
REQ-033 Rounding SHALL be a combinational sub-module fp_round (mantissa, G/R/S in -> rounded mantissa, carry, inexact out).

Verification
REQ-034 sign0 exp127 mant 0x4000000 -> result 0x3F800000, flags 0, out_valid 2 edges after accept.
REQ-035 exp130 mant 0x0000008 -> 23 shifts, result 0x35800000, out_valid 25 edges after accept.
REQ-036 exp127 mant 0xC000000 -> right shift, result 0x40400000, flags 0.
REQ-037 exp127 mant 0x4000004 -> result 0x3F800000, inexact=1 (tie down).
REQ-038 exp127 mant 0x400000C -> result 0x3F800002, inexact=1 (tie up).
REQ-039 exp254 mant 0xFFFFFFF -> 0x7F800000, overflow=1; out_ready low 5 cycles holds output; rst_n pulse mid-NORM -> out_valid 0, in_ready 1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the normalise/round/pack stage of the FP adder.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 28;
    localparam int FRAC_W  = 23;
    localparam int EXP_MAX = 255;
    localparam int BIAS    = 127;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Assemble an IEEE-754 single from its three fields.
    function automatic logic [31:0] pack_fp(input logic s,
                                            input logic [EXP_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp_round.sv
// Round-to-nearest-even of a 24-bit significand (hidden bit + fraction) using G/R/S.
module fp_round
    import fp_pkg::*;
(
    input  logic [FRAC_W:0] mant,
    input  logic            guard_bit,
    input  logic            round_bit,
    input  logic            sticky_bit,
    output logic [FRAC_W:0] mant_rnd,
    output logic            carry,
    output logic            inexact
);

    logic            inc_s;
    logic [FRAC_W+1:0] sum_s;

    // Increment on more-than-half, or exactly half with an odd LSB.
    always_comb begin
        inc_s   = guard_bit && (round_bit || sticky_bit || mant[0]);
        sum_s   = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, inc_s};
        carry   = sum_s[FRAC_W+1];
        inexact = guard_bit || round_bit || sticky_bit;
        if (carry) begin
            mant_rnd = {1'b1, {FRAC_W{1'b0}}};
        end else begin
            mant_rnd = sum_s[FRAC_W:0];
        end
    end

endmodule

// File: rtl/fp_normalize_pack.sv
// Normalises a raw adder sum one bit per cycle, rounds it to nearest-even and
// packs it as an IEEE-754 single with overflow/underflow/inexact flags.
module fp_normalize_pack
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mantis,
    input  logic              in_loss,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic [2:0]        flags
);

    // Two spare exponent bits absorb the +1 from a carry shift and a rounding carry.
    localparam int XEXP_W = EXP_W + 2;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                sign_r;
    logic                pass_r;
    logic [XEXP_W-1:0]   exp_r;
    logic [MANT_W-1:0]   mant_r;
    logic                out_valid_r;
    logic [31:0]         result_r;
    logic [2:0]          flags_r;

    logic                norm_left_s;
    logic [FRAC_W:0]     mant_rnd_s;
    logic                carry_s;
    logic                inexact_s;
    logic [XEXP_W-1:0]   exp_fin_s;
    logic [31:0]         result_s;
    logic [2:0]          flags_s;

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;

    assign norm_left_s = !mant_r[MANT_W-1] && !mant_r[MANT_W-2]
                         && (mant_r != {MANT_W{1'b0}})
                         && (exp_r > XEXP_W'(1));

    fp_round u_round (
        .mant       (mant_r[MANT_W-2:3]),
        .guard_bit  (mant_r[2]),
        .round_bit  (mant_r[1]),
        .sticky_bit (mant_r[0]),
        .mant_rnd   (mant_rnd_s),
        .carry      (carry_s),
        .inexact    (inexact_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; infinities/NaNs skip normalisation entirely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_NORM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (pass_r || !norm_left_s) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_NORM;
                end
            end
            ST_ROUND: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Result selection: pass-through, zero, overflow, or rounded normal/denormal.
    always_comb begin
        exp_fin_s = exp_r + {{(XEXP_W-1){1'b0}}, carry_s};
        result_s  = 32'h0000_0000;
        flags_s   = 3'b000;
        if (pass_r) begin
            result_s = pack_fp(sign_r, 8'hFF, mant_r[FRAC_W+2:3]);
            flags_s  = 3'b000;
        end else if (mant_r == {MANT_W{1'b0}}) begin
            result_s = 32'h0000_0000;
            flags_s  = 3'b000;
        end else if (exp_fin_s >= XEXP_W'(EXP_MAX)) begin
            result_s = pack_fp(sign_r, 8'hFF, {FRAC_W{1'b0}});
            flags_s  = 3'b101;
        end else begin
            result_s = pack_fp(sign_r,
                               mant_rnd_s[FRAC_W] ? exp_fin_s[EXP_W-1:0] : 8'h00,
                               mant_rnd_s[FRAC_W-1:0]);
            flags_s  = {1'b0, !mant_r[MANT_W-2] && inexact_s, inexact_s};
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r      <= 1'b0;
            pass_r      <= 1'b0;
            exp_r       <= {XEXP_W{1'b0}};
            mant_r      <= {MANT_W{1'b0}};
            out_valid_r <= 1'b0;
            result_r    <= 32'h0000_0000;
            flags_r     <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_sign;
                        pass_r <= (in_exp == 8'hFF);
                        exp_r  <= {2'b00, in_exp};
                        mant_r <= {in_mantis[MANT_W-1:1], in_mantis[0] | in_loss};
                    end
                end
                ST_NORM: begin
                    if (!pass_r) begin
                        if (mant_r[MANT_W-1]) begin
                            mant_r <= {1'b0, mant_r[MANT_W-1:2], mant_r[1] | mant_r[0]};
                            exp_r  <= exp_r + XEXP_W'(1);
                        end else if (norm_left_s) begin
                            mant_r <= {mant_r[MANT_W-2:0], 1'b0};
                            exp_r  <= exp_r - XEXP_W'(1);
                        end
                    end
                end
                ST_ROUND: begin
                    result_r    <= result_s;
                    flags_r     <= flags_s;
                    out_valid_r <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Scoreboard bench for fp_normalize_pack: directed corner cases plus random sums
// checked against an arithmetic reference model.
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [27:0] in_mantis = 28'd0;
    logic        in_loss = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [2:0]  flags;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        int          stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   seen = 1'b0;
    int   stall_left = 0;

    fp_normalize_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mantis (in_mantis),
        .in_loss   (in_loss),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value-level normalise, round-half-even in integer arithmetic, then pack.
    function automatic void model(input logic s, input logic [7:0] ei, input logic [27:0] mi,
                                  input logic li, output logic [31:0] r, output logic [2:0] f,
                                  output int lat);
        logic [27:0] m;
        int e, k, p, frac, grs, q;
        bit inx, tiny;
        lat = 2;
        m = mi | {27'd0, li};
        e = int'(ei);
        if (ei == 8'd255) begin
            r = {s, 8'hFF, mi[25:3]};
            f = 3'b000;
        end else if (m == 28'd0) begin
            r = 32'd0;
            f = 3'b000;
        end else begin
            if (m[27]) begin
                m = (m >> 1) | (m & 28'd1);
                e = e + 1;
            end else begin
                p = 0;
                for (int i = 0; i < 27; i++) if (m[i]) p = i;
                k = 26 - p;
                if (k > e - 1) k = (e > 1) ? e - 1 : 0;
                m = m << k;
                e = e - k;
                lat = 2 + k;
            end
            frac = int'(m[26:3]);
            grs  = int'(m[2:0]);
            inx  = (grs != 0);
            tiny = !m[26];
            q = frac + (((grs > 4) || (grs == 4 && (frac % 2) == 1)) ? 1 : 0);
            if (q == (1 << 24)) begin
                q = 1 << 23;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 3'b101;
            end else begin
                r = {s, (q >= (1 << 23)) ? e[7:0] : 8'd0, q[22:0]};
                f = {1'b0, tiny && inx, inx};
            end
        end
    endfunction

    task automatic send_exp(input logic s, input logic [7:0] e, input logic [27:0] m,
                            input logic l, input int stall, input logic [31:0] xr,
                            input logic [2:0] xf, input int xlat);
        int waitc = 0;
        exp_t ent;
        @(negedge clk);
        while (!in_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
            return;
        end
        ent.res = xr; ent.flg = xf; ent.lat = xlat; ent.stall = stall;
        sb_q.push_back(ent);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mantis = m; in_loss = l;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        // Garbage while busy must be ignored.
        in_valid  = 1'($urandom_range(0, 1));
        in_mantis = 28'($urandom);
        in_exp    = 8'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic s, input logic [7:0] e, input logic [27:0] m,
                             input logic l, input int stall);
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        model(s, e, m, l, r, f, lat);
        send_exp(s, e, m, l, stall, r, f, lat);
    endtask

    // Monitor: compares every cycle the output is presented, drives out_ready after a stall.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
            out_ready = 1'b0;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_valid: out_valid 1 with nothing outstanding");
                out_ready = 1'b1;
            end else begin
                e = sb_q[0];
                chk("result", 64'(result), 64'(e.res));
                chk("flags", 64'(flags), 64'(e.flg));
                if (!seen) begin
                    chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                    seen = 1'b1;
                    stall_left = e.stall;
                end
                if (stall_left == 0) begin
                    out_ready = 1'b1;
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end else begin
                    out_ready = 1'b0;
                    stall_left--;
                end
            end
        end else begin
            if (seen) begin
                n_cmp++;
                n_fail++;
                $display("FAIL valid_drop: out_valid 0 before handshake, expected 1");
                seen = 1'b0;
            end
            out_ready = 1'b0;
        end
    end

    initial begin
        logic [27:0] m;
        logic [7:0]  e;
        int          waitc;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        send_exp(1'b0, 8'd127, 28'h4000000, 1'b0, 0, 32'h3F800000, 3'b000, 2);
        send_exp(1'b0, 8'd130, 28'h0000008, 1'b0, 1, 32'h35800000, 3'b000, 25);
        send_exp(1'b0, 8'd127, 28'hC000000, 1'b0, 0, 32'h40400000, 3'b000, 2);
        send_exp(1'b0, 8'd127, 28'h4000004, 1'b0, 0, 32'h3F800000, 3'b001, 2);
        send_exp(1'b0, 8'd127, 28'h400000C, 1'b0, 2, 32'h3F800002, 3'b001, 2);
        send_exp(1'b0, 8'd254, 28'hFFFFFFF, 1'b0, 5, 32'h7F800000, 3'b101, 2);
        send_exp(1'b1, 8'd100, 28'h0000000, 1'b0, 0, 32'h00000000, 3'b000, 2);
        send_exp(1'b1, 8'd255, 28'h4ABCDE8, 1'b1, 0, 32'hFF9579BD, 3'b000, 2);
        send_exp(1'b0, 8'd1,   28'h0000008, 1'b1, 0, 32'h00000001, 3'b011, 2);

        // Reset pulse in the middle of a long normalisation.
        send_exp(1'b0, 8'd130, 28'h0000008, 1'b0, 0, 32'h35800000, 3'b000, 25);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midnorm_out_valid", 64'(out_valid), 64'd0);
        chk("midnorm_result", 64'(result), 64'd0);
        chk("midnorm_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int n = 0; n < 150; n++) begin
            m = 28'($urandom);
            case ($urandom_range(0, 9))
                0:       m = 28'd0;
                1, 2:    m = m >> $urandom_range(1, 27);
                3:       m = {2'b01, m[25:0]};
                default: m = m;
            endcase
            case ($urandom_range(0, 7))
                0:       e = 8'd255;
                1:       e = 8'd254;
                2:       e = 8'($urandom_range(0, 3));
                default: e = 8'($urandom_range(0, 255));
            endcase
            send_rand(1'($urandom_range(0, 1)), e, m, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3));
        end

        waitc = 0;
        while (sb_q.size() != 0 && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
